clkgen_seq: RTL and testbench

Parametrised clock-enable generator and reset sequencer running in the MMCM output clock domain (e.g. the 4x colour clock). It qualifies the MMCM `locked` flag and holds downstream logic in reset until lock has been stable for a programmable time. In run state it produces CHANNELS independent fractional-N clock enables from phase accumulators, replacing fixed per-frequency MMCM outputs. It sits directly after the MMCM/BUFG and feeds the video timing and dot-clock logic.

---
 rtl/clkgen_pkg.sv | 18 +
 rtl/clkgen_seq_phase_accum.sv | 43 ++++
 rtl/clkgen_seq.sv | 121 ++++++++++++
 tb/tb_clkgen_seq.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// Shared constants for the colour-clock enable generator and reset sequencer.
package clkgen_pkg;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  // Standard phase increments, 24-bit accumulator against the colour-4x clock
  // (NTSC 14.318182 MHz, PAL 17.734475 MHz).
  localparam int unsigned STD_ACC_WIDTH = 24;
  localparam logic [23:0] INC_NTSC_COLOR    = 24'h400000;     // 3.579545 MHz, exactly 1/4
  localparam logic [23:0] INC_PAL_COLOR     = 24'h400000;     // 4.433619 MHz, exactly 1/4
  localparam logic [23:0] INC_NTSC_DOT_13M5 = 24'd15818518;   // 13.5 MHz, 33/35 of clock
  localparam logic [23:0] INC_NTSC_DOT_SQ   = 24'd14380471;   // 12.272727 MHz, 6/7 of clock
  localparam logic [23:0] INC_PAL_DOT_13M5  = 24'd12771307;   // 13.5 MHz, approx 0.76123

endpackage

// File: rtl/clkgen_seq_phase_accum.sv
// One fractional-N clock-enable channel: phase accumulator with carry-out enable.
import clkgen_pkg::*;

module phase_accum #(
  parameter int unsigned ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 load,
  input  logic [ACC_WIDTH-1:0] inc,
  output logic                 ce,
  output logic                 msb
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] inc_act;

  // Increment load is independent of clear, so phase stays continuous across reloads
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      inc_act <= '0;
      ce      <= 1'b0;
    end else begin
      if (load) begin
        inc_act <= inc;
      end
      if (clear) begin
        acc <= '0;
        ce  <= 1'b0;
      end else if (enable) begin
        {ce, acc} <= {1'b0, acc} + {1'b0, inc_act};
      end else begin
        ce <= 1'b0;
      end
    end
  end

  assign msb = acc[ACC_WIDTH-1];

endmodule

// File: rtl/clkgen_seq.sv
// Lock-qualifying reset sequencer with CHANNELS fractional-N clock enables.
import clkgen_pkg::*;

module clkgen_seq #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned LOCK_WAIT = 1024
) (
  input  logic                          clk_color4x,
  input  logic                          reset,
  input  logic                          locked,
  input  logic [CHANNELS*ACC_WIDTH-1:0] inc,
  input  logic                          inc_load,
  output logic                          run,
  output logic                          rst_out,
  output logic [CHANNELS-1:0]           ce,
  output logic [CHANNELS-1:0]           phase_msb,
  output logic [7:0]                    lost_count
);

  localparam int unsigned CNT_W = $clog2(LOCK_WAIT + 1);

  logic             sync1;
  logic             locked_s;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       lost_nxt;
  logic             run_nxt;
  logic             accum_en_c;
  logic             clear_c;

  // Two-flop synchroniser for the asynchronous MMCM lock flag
  always_ff @(posedge clk_color4x) begin
    if (reset) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= locked;
      locked_s <= sync1;
    end
  end

  // Sequencer state, settle counter, loss counter and registered run/reset outputs
  always_ff @(posedge clk_color4x) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lost_count <= 8'd0;
      run        <= 1'b0;
      rst_out    <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      lost_count <= lost_nxt;
      run        <= run_nxt;
      rst_out    <= ~run_nxt;
    end
  end

  // Next-state logic: lock must hold LOCK_WAIT settle cycles; any drop restarts from IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lost_nxt  = lost_count;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (locked_s) begin
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!locked_s) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(LOCK_WAIT - 1)) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          if (lost_count != 8'hFF) begin
            lost_nxt = lost_count + 8'd1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    run_nxt = (state_nxt == ST_RUN);
  end

  // Accumulate only while staying in RUN; the edge that leaves RUN clears instead
  assign accum_en_c = (state == ST_RUN) && locked_s;
  assign clear_c    = ~accum_en_c;

  // One accumulator per enable channel
  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    phase_accum #(
      .ACC_WIDTH(ACC_WIDTH)
    ) u_accum (
      .clk    (clk_color4x),
      .reset  (reset),
      .clear  (clear_c),
      .enable (accum_en_c),
      .load   (inc_load),
      .inc    (inc[n*ACC_WIDTH +: ACC_WIDTH]),
      .ce     (ce[n]),
      .msb    (phase_msb[n])
    );
  end

endmodule

// File: tb/tb_clkgen_seq.sv
// Scoreboard bench for clkgen_seq: streak-based reference model plus directed checks.
module tb_clkgen_seq;

  localparam int W  = 24;
  localparam int LW = 16;
  localparam int CH = 2;

  logic          clk;
  logic          reset;
  logic          locked;
  logic [CH*W-1:0] inc;
  logic          inc_load;
  logic          run;
  logic          rst_out;
  logic [CH-1:0] ce;
  logic [CH-1:0] phase_msb;
  logic [7:0]    lost_count;

  clkgen_seq #(
    .CHANNELS  (CH),
    .ACC_WIDTH (W),
    .LOCK_WAIT (LW)
  ) dut (
    .clk_color4x (clk),
    .reset       (reset),
    .locked      (locked),
    .inc         (inc),
    .inc_load    (inc_load),
    .run         (run),
    .rst_out     (rst_out),
    .ce          (ce),
    .phase_msb   (phase_msb),
    .lost_count  (lost_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          run;
    logic          rst_out;
    logic [CH-1:0] ce;
    logic [CH-1:0] msb;
    logic [7:0]    lost;
  } exp_t;

  typedef struct {
    string name;
    int    got;
    int    exp;
  } dchk_t;

  exp_t  sb[$];
  dchk_t dq[$];
  int    checks = 0;
  int    passes = 0;
  bit    done   = 1'b0;

  // Reference model: run holds once locked_s has been seen high on LW+1 consecutive edges
  bit          m_known = 1'b0;
  bit          m_s1, m_s2, m_run, m_ls_pre, m_run_next;
  int          m_streak;
  int          m_lost;
  longint      m_acc [CH];
  longint      m_inc [CH];
  bit [CH-1:0] m_ce;
  bit [CH-1:0] m_msb;
  longint      m_sum;
  exp_t        m_e;

  always @(posedge clk) begin
    if (reset) begin
      m_known  = 1'b1;
      m_s1     = 1'b0;
      m_s2     = 1'b0;
      m_run    = 1'b0;
      m_streak = 0;
      m_lost   = 0;
      m_ce     = '0;
      for (int c = 0; c < CH; c++) begin
        m_acc[c] = 0;
        m_inc[c] = 0;
      end
    end else if (m_known) begin
      m_ls_pre = m_s2;
      m_s2     = m_s1;
      m_s1     = locked;
      m_streak = m_ls_pre ? ((m_streak > LW) ? m_streak : m_streak + 1) : 0;
      m_run_next = (m_streak >= LW + 1);
      if (m_run && !m_ls_pre && m_lost < 255) m_lost = m_lost + 1;
      for (int c = 0; c < CH; c++) begin
        if (m_run && m_run_next) begin
          m_sum    = m_acc[c] + m_inc[c];
          m_ce[c]  = (m_sum >= (64'd1 << W));
          m_acc[c] = m_sum % (64'd1 << W);
        end else begin
          m_acc[c] = 0;
          m_ce[c]  = 1'b0;
        end
        if (inc_load) m_inc[c] = longint'(inc[c*W +: W]);
      end
      m_run = m_run_next;
    end
    if (m_known) begin
      for (int c = 0; c < CH; c++) m_msb[c] = m_acc[c][W-1];
      m_e.run     = m_run;
      m_e.rst_out = !m_run;
      m_e.ce      = m_ce;
      m_e.msb     = m_msb;
      m_e.lost    = 8'(m_lost);
      sb.push_back(m_e);
    end
  end

  // Monitor: sole owner of the check counters
  exp_t  g;
  exp_t  e;
  dchk_t d;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      g.run = run; g.rst_out = rst_out; g.ce = ce; g.msb = phase_msb; g.lost = lost_count;
      checks++;
      if (g === e) passes++;
      else $display("FAIL outputs t=%0t got run=%b rst=%b ce=%b msb=%b lost=%0d exp run=%b rst=%b ce=%b msb=%b lost=%0d",
                    $time, g.run, g.rst_out, g.ce, g.msb, g.lost, e.run, e.rst_out, e.ce, e.msb, e.lost);
    end
    while (dq.size() > 0) begin
      d = dq.pop_front();
      checks++;
      if (d.got == d.exp) passes++;
      else $display("FAIL %s got=%0d exp=%0d", d.name, d.got, d.exp);
    end
    if (done) begin
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic dcheck(input string name, input int got, input int exp);
    dq.push_back('{name, got, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Edges until run rises, counting the first edge after the call as 1
  task automatic wait_run(output int n);
    n = 999;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (run === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_low(output int n);
    n = 999;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (run === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic count_ce(input int edges, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    repeat (edges) begin
      @(posedge clk);
      #1;
      c0 += int'(ce[0]);
      c1 += int'(ce[1]);
    end
  endtask

  int n, c0, c1;

  initial begin
    reset    = 1'b1;
    locked   = 1'b0;
    inc      = '0;
    inc_load = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Load ch0 = 2^23, ch1 = 2^22 while idle
    inc = {24'h400000, 24'h800000};
    inc_load = 1'b1;
    step();
    inc_load = 1'b0;
    dcheck("reset_run", int'(run), 0);
    dcheck("reset_rst_out", int'(rst_out), 1);
    dcheck("reset_lost", int'(lost_count), 0);
    dcheck("reset_ce", int'(ce), 0);

    // Acquisition latency and enable spacing
    locked = 1'b1;
    wait_run(n);
    dcheck("acq_edges", n, LW + 3);
    dcheck("acq_rst_out", int'(rst_out), 0);
    count_ce(16, c0, c1);
    dcheck("ce0_half_rate", c0, 8);
    dcheck("ce1_quarter_rate", c1, 4);

    // Reload ch0 to 2^22 in RUN: spacing widens without an accumulator reset
    inc[W-1:0] = 24'h400000;
    inc_load = 1'b1;
    step();
    inc_load = 1'b0;
    count_ce(16, c0, c1);
    dcheck("ce0_after_reload", c0, 4);

    // Zero increment produces no enables
    inc[W-1:0] = 24'h000000;
    inc_load = 1'b1;
    step();
    inc_load = 1'b0;
    count_ce(20, c0, c1);
    dcheck("ce0_zero_inc", c0, 0);

    // Lock loss in RUN
    locked = 1'b0;
    wait_low(n);
    dcheck("loss_edges", n, 3);
    dcheck("loss_lost_count", int'(lost_count), 1);
    dcheck("loss_ce", int'(ce), 0);

    // One-cycle glitch during SETTLE restarts the count
    locked = 1'b1;
    repeat (11) step();
    locked = 1'b0;
    step();
    locked = 1'b1;
    wait_run(n);
    dcheck("glitch_reacq_edges", n, LW + 3);

    // Loss counter saturation
    for (int i = 0; i < 260; i++) begin
      locked = 1'b0;
      repeat (4) step();
      locked = 1'b1;
      wait_run(n);
      if (i == 0 || i == 259) dcheck("sat_reacq_edges", n, LW + 3);
    end
    locked = 1'b0;
    repeat (4) step();
    dcheck("lost_saturated", int'(lost_count), 255);

    // Reset in RUN with lost_count = 5
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      locked = 1'b1;
      wait_run(n);
      locked = 1'b0;
      repeat (4) step();
    end
    dcheck("lost_five", int'(lost_count), 5);
    locked = 1'b1;
    wait_run(n);
    reset = 1'b1;
    @(posedge clk);
    #1;
    dcheck("mid_reset_run", int'(run), 0);
    dcheck("mid_reset_rst_out", int'(rst_out), 1);
    dcheck("mid_reset_ce", int'(ce), 0);
    dcheck("mid_reset_msb", int'(phase_msb), 0);
    dcheck("mid_reset_lost", int'(lost_count), 0);

    // Reacquire after reset with ch0 = 3*2^16: three enables per 256 cycles
    reset = 1'b0;
    inc = {24'h000001, 24'h030000};
    inc_load = 1'b1;
    wait_run(n);
    inc_load = 1'b0;
    dcheck("post_reset_reacq_edges", n, LW + 3);
    count_ce(256, c0, c1);
    dcheck("ce0_3_per_256", c0, 3);
    dcheck("ce1_slow", c1, 0);

    // Randomised lock, reload and reset traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      int sel;
      r = int'($urandom_range(0, 999));
      if (locked) begin
        if (r < 15) locked = 1'b0;
      end else if (r < 300) begin
        locked = 1'b1;
      end
      reset    = ($urandom_range(0, 999) < 2);
      inc_load = ($urandom_range(0, 99) < 4);
      if (inc_load) begin
        for (int c = 0; c < CH; c++) begin
          sel = int'($urandom_range(0, 7));
          case (sel)
            0:       inc[c*W +: W] = 24'h000000;
            1:       inc[c*W +: W] = 24'hFFFFFF;
            2:       inc[c*W +: W] = 24'h800000;
            default: inc[c*W +: W] = 24'($urandom);
          endcase
        end
      end
      step();
    end
    reset    = 1'b0;
    inc_load = 1'b0;
    step();
    step();
    done = 1'b1;
  end

endmodule
